// File: rtl/sky130_fd_io__sio_seq_pkg.sv
// Shared types for the SIO macro sequencer: FSM states and the per-pad configuration record.
package sky130_fd_io__sio_seq_pkg;

    typedef enum logic [2:0] {
        OFF,
        ENABLE,
        REF_UP,
        SETTLE,
        IDLE,
        APPLY,
        RELEASE
    } seq_state_t;

    typedef struct packed {
        logic [2:0] dm;
        logic       vtrip;
        logic       ibuf;
        logic       vreg;
        logic       slow;
        logic       inp_dis;
    } pad_cfg_t;

    // Input buffer disabled is the safe power-down value for the pad.
    localparam pad_cfg_t PAD_CFG_RST = '{dm: 3'b000, vtrip: 1'b0, ibuf: 1'b0,
                                         vreg: 1'b0, slow: 1'b0, inp_dis: 1'b1};

endpackage

// File: rtl/sky130_fd_io__sio_macro_seq_if.sv
// Sequencer bus: configuration requester handshake plus the SIO macro control pins.
interface sky130_fd_io__sio_macro_seq_if;

    logic       POWER_GOOD;
    logic       CFG_VALID;
    logic       CFG_READY;
    logic       CFG_PAD;
    logic [2:0] CFG_DM;
    logic       CFG_VTRIP;
    logic       CFG_IBUF;
    logic       CFG_VREG;
    logic       CFG_SLOW;
    logic       CFG_INP_DIS;
    logic       ENABLE_H;
    logic       ENABLE_VDDA_H;
    logic       HLD_H_N_REFGEN;
    logic       VREG_EN_REFGEN;
    logic [1:0] HLD_H_N;
    logic [2:0] DM0;
    logic [2:0] DM1;
    logic [1:0] VTRIP_SEL;
    logic [1:0] IBUF_SEL;
    logic [1:0] VREG_EN;
    logic [1:0] SLOW;
    logic [1:0] INP_DIS;
    logic       SEQ_DONE;

    modport master (
        output POWER_GOOD, CFG_VALID, CFG_PAD, CFG_DM, CFG_VTRIP, CFG_IBUF,
               CFG_VREG, CFG_SLOW, CFG_INP_DIS,
        input  CFG_READY, ENABLE_H, ENABLE_VDDA_H, HLD_H_N_REFGEN, VREG_EN_REFGEN,
               HLD_H_N, DM0, DM1, VTRIP_SEL, IBUF_SEL, VREG_EN, SLOW, INP_DIS, SEQ_DONE
    );

    modport slave (
        input  POWER_GOOD, CFG_VALID, CFG_PAD, CFG_DM, CFG_VTRIP, CFG_IBUF,
               CFG_VREG, CFG_SLOW, CFG_INP_DIS,
        output CFG_READY, ENABLE_H, ENABLE_VDDA_H, HLD_H_N_REFGEN, VREG_EN_REFGEN,
               HLD_H_N, DM0, DM1, VTRIP_SEL, IBUF_SEL, VREG_EN, SLOW, INP_DIS, SEQ_DONE
    );

endinterface

// File: rtl/sky130_fd_io__sio_seq_padcfg.sv
// Per-pad configuration register with synchronous clear and load enable.
module sky130_fd_io__sio_seq_padcfg
    import sky130_fd_io__sio_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     load,
    input  pad_cfg_t d,
    output pad_cfg_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= PAD_CFG_RST;
        end else if (clr) begin
            q <= PAD_CFG_RST;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sky130_fd_io__sio_macro_seq.sv
// SIO macro power-up / reconfiguration sequencer with registered control outputs.
// SIO_SEQ_FAST_SIM_EN forces settle=8 and hold=2 cycles for gate-level/mixed-signal runs.
module sky130_fd_io__sio_macro_seq
    import sky130_fd_io__sio_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int CNT_W         = 11
)
(
    input  logic                          CLK,
    input  logic                          RESET_B,
    sky130_fd_io__sio_macro_seq_if.slave  bus
);

`ifdef SIO_SEQ_FAST_SIM_EN
    localparam int SETTLE_N = 8;
    localparam int HOLD_N   = 2;
`else
    localparam int SETTLE_N = SETTLE_CYCLES;
    localparam int HOLD_N   = HOLD_CYCLES;
`endif

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_N - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_N - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             pg;
    pad_cfg_t         cfg_in;
    pad_cfg_t         cfg0;
    pad_cfg_t         cfg1;

    logic             en_q, en_nxt;
    logic             ref_q, ref_nxt;
    logic             done_q, done_nxt;
    logic             ready_q, ready_nxt;
    logic [1:0]       hold_q, hold_nxt;

    assign pg     = bus.POWER_GOOD;
    assign xfer   = bus.CFG_VALID & ready_q & (state == IDLE);
    assign cfg_in = {bus.CFG_DM, bus.CFG_VTRIP, bus.CFG_IBUF, bus.CFG_VREG,
                     bus.CFG_SLOW, bus.CFG_INP_DIS};

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OFF:     if (pg) state_nxt = ENABLE;
            ENABLE:  state_nxt = REF_UP;
            REF_UP:  state_nxt = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) state_nxt = IDLE;
            IDLE:    if (xfer) state_nxt = APPLY;
            APPLY:   if (cnt == HOLD_LAST) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = OFF;
        endcase
        if (!pg) state_nxt = OFF;
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            cnt <= '0;
        end else if (state == REF_UP || xfer) begin
            cnt <= '0;
        end else if (state == SETTLE || state == APPLY) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Output values follow the current state one edge later, except that the
    // pad hold drops on the accepting edge together with the new configuration.
    always_comb begin
        en_nxt    = 1'b0;
        ref_nxt   = 1'b0;
        done_nxt  = 1'b0;
        ready_nxt = 1'b0;
        hold_nxt  = 2'b00;
        if (pg) begin
            en_nxt    = (state != OFF);
            ref_nxt   = (state != OFF) && (state != ENABLE);
            done_nxt  = (state == IDLE) || (state == APPLY) || (state == RELEASE);
            ready_nxt = (state == IDLE) && !xfer;
            case (state)
                IDLE:    hold_nxt = xfer ? (bus.CFG_PAD ? 2'b01 : 2'b10) : 2'b11;
                APPLY:   hold_nxt = hold_q;
                RELEASE: hold_nxt = 2'b11;
                default: hold_nxt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            en_q    <= 1'b0;
            ref_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 2'b00;
        end else begin
            en_q    <= en_nxt;
            ref_q   <= ref_nxt;
            done_q  <= done_nxt;
            ready_q <= ready_nxt;
            hold_q  <= hold_nxt;
        end
    end

    sky130_fd_io__sio_seq_padcfg u_pad0 (
        .clk   (CLK),
        .rst_n (RESET_B),
        .clr   (!pg),
        .load  (xfer && !bus.CFG_PAD),
        .d     (cfg_in),
        .q     (cfg0)
    );

    sky130_fd_io__sio_seq_padcfg u_pad1 (
        .clk   (CLK),
        .rst_n (RESET_B),
        .clr   (!pg),
        .load  (xfer && bus.CFG_PAD),
        .d     (cfg_in),
        .q     (cfg1)
    );

    assign bus.ENABLE_H       = en_q;
    assign bus.ENABLE_VDDA_H  = en_q;
    assign bus.HLD_H_N_REFGEN = ref_q;
    assign bus.VREG_EN_REFGEN = ref_q;
    assign bus.SEQ_DONE       = done_q;
    assign bus.CFG_READY      = ready_q;
    assign bus.HLD_H_N        = hold_q;
    assign bus.DM0            = cfg0.dm;
    assign bus.DM1            = cfg1.dm;
    assign bus.VTRIP_SEL      = {cfg1.vtrip,   cfg0.vtrip};
    assign bus.IBUF_SEL       = {cfg1.ibuf,    cfg0.ibuf};
    assign bus.VREG_EN        = {cfg1.vreg,    cfg0.vreg};
    assign bus.SLOW           = {cfg1.slow,    cfg0.slow};
    assign bus.INP_DIS        = {cfg1.inp_dis, cfg0.inp_dis};

endmodule

// File: tb/tb_sky130_fd_io__sio_macro_seq.sv
// Directed bench for the SIO macro sequencer: bring-up, writes, power loss and reset.
module tb_sky130_fd_io__sio_macro_seq;

`ifdef SIO_SEQ_FAST_SIM_EN
    localparam int S = 8;
    localparam int H = 2;
`else
    localparam int S = 16;
    localparam int H = 4;
`endif

    localparam logic [23:0] RST_VEC = 24'h00000C;

    logic CLK = 1'b0;
    logic RESET_B;
    int   n_chk = 0;
    int   n_bad = 0;
    int   ovl;

    sky130_fd_io__sio_macro_seq_if bus();

    sky130_fd_io__sio_macro_seq #(
        .SETTLE_CYCLES (16),
        .HOLD_CYCLES   (4),
        .CNT_W         (11)
    ) u_dut (
        .CLK     (CLK),
        .RESET_B (RESET_B),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    wire [23:0] outs = {bus.ENABLE_H, bus.ENABLE_VDDA_H, bus.HLD_H_N_REFGEN, bus.VREG_EN_REFGEN,
                        bus.HLD_H_N, bus.DM0, bus.DM1, bus.VTRIP_SEL, bus.IBUF_SEL,
                        bus.VREG_EN, bus.SLOW, bus.INP_DIS, bus.CFG_READY, bus.SEQ_DONE};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // f = {vtrip, ibuf, vreg, slow, inp_dis}
    task automatic set_cfg(input logic pad, input logic [2:0] dm, input logic [4:0] f);
        bus.CFG_PAD     = pad;
        bus.CFG_DM      = dm;
        bus.CFG_VTRIP   = f[4];
        bus.CFG_IBUF    = f[3];
        bus.CFG_VREG    = f[2];
        bus.CFG_SLOW    = f[1];
        bus.CFG_INP_DIS = f[0];
    endtask

    // Caller guarantees POWER_GOOD=1 and the next rising edge is edge 0.
    task automatic bringup(input string tag);
        tick();
        chk({tag, "_e0_all"}, 32'(outs), 32'(RST_VEC));
        tick();
        chk({tag, "_e1_en"}, {30'd0, bus.ENABLE_H, bus.ENABLE_VDDA_H}, 32'd3);
        chk({tag, "_e1_ref"}, {30'd0, bus.HLD_H_N_REFGEN, bus.VREG_EN_REFGEN}, 32'd0);
        tick();
        chk({tag, "_e2_ref"}, {30'd0, bus.HLD_H_N_REFGEN, bus.VREG_EN_REFGEN}, 32'd3);
        for (int i = 3; i < 3 + S; i++) tick();
        chk({tag, "_pre_done"}, {30'd0, bus.SEQ_DONE, bus.CFG_READY}, 32'd0);
        chk({tag, "_pre_hold"}, 32'(bus.HLD_H_N), 32'd0);
        tick();
        chk({tag, "_done_rdy"}, {30'd0, bus.SEQ_DONE, bus.CFG_READY}, 32'd3);
        chk({tag, "_done_hold"}, 32'(bus.HLD_H_N), 32'd3);
        chk({tag, "_done_inp"}, 32'(bus.INP_DIS), 32'd3);
    endtask

    initial begin
        RESET_B        = 1'b0;
        bus.POWER_GOOD = 1'b0;
        bus.CFG_VALID  = 1'b0;
        set_cfg(1'b0, 3'b000, 5'b00000);
        #12;
        chk("reset_all", 32'(outs), 32'(RST_VEC));
        tick();
        RESET_B = 1'b1;
        tick();
        chk("off_pg_low", 32'(outs), 32'(RST_VEC));
        bus.POWER_GOOD = 1'b1;
        bringup("up1");

        // Single write to pad 1.
        set_cfg(1'b1, 3'b110, 5'b11010);
        bus.CFG_VALID = 1'b1;
        tick();
        bus.CFG_VALID = 1'b0;
        chk("w1_hold", 32'(bus.HLD_H_N), 32'h1);
        chk("w1_dm1", 32'(bus.DM1), 32'h6);
        chk("w1_dm0", 32'(bus.DM0), 32'h0);
        chk("w1_inp", 32'(bus.INP_DIS), 32'h1);
        chk("w1_vtrip", 32'(bus.VTRIP_SEL), 32'h2);
        chk("w1_slow", 32'(bus.SLOW), 32'h2);
        chk("w1_rdy", 32'(bus.CFG_READY), 32'h0);
        for (int k = 1; k <= H; k++) begin
            tick();
            chk("w1_hold_low", 32'(bus.HLD_H_N), 32'h1);
        end
        tick();
        chk("w1_release", 32'(bus.HLD_H_N), 32'h3);
        chk("w1_rdy_rel", 32'(bus.CFG_READY), 32'h0);
        tick();
        chk("w1_rdy_back", 32'(bus.CFG_READY), 32'h1);

        // Back-to-back: pad 0 then pad 1 with CFG_VALID held.
        set_cfg(1'b0, 3'b011, 5'b00100);
        bus.CFG_VALID = 1'b1;
        tick();
        set_cfg(1'b1, 3'b101, 5'b00101);
        chk("b0_hold", 32'(bus.HLD_H_N), 32'h2);
        chk("b0_dm0", 32'(bus.DM0), 32'h3);
        chk("b0_dm1_kept", 32'(bus.DM1), 32'h6);
        chk("b0_vreg", 32'(bus.VREG_EN), 32'h1);
        chk("b0_inp", 32'(bus.INP_DIS), 32'h0);
        ovl = 0;
        for (int k = 1; k <= H + 1; k++) begin
            tick();
            if (bus.HLD_H_N == 2'b00) ovl++;
        end
        chk("b0_release", 32'(bus.HLD_H_N), 32'h3);
        tick();
        chk("b1_rdy", 32'(bus.CFG_READY), 32'h1);
        chk("b1_gap_hold", 32'(bus.HLD_H_N), 32'h3);
        tick();
        bus.CFG_VALID = 1'b0;
        chk("b1_hold", 32'(bus.HLD_H_N), 32'h1);
        chk("b1_dm1", 32'(bus.DM1), 32'h5);
        chk("b1_dm0_kept", 32'(bus.DM0), 32'h3);
        chk("b1_vreg", 32'(bus.VREG_EN), 32'h3);
        chk("b1_inp", 32'(bus.INP_DIS), 32'h2);
        chk("b2b_overlap", 32'(ovl), 32'd0);

        // Power loss mid-APPLY.
        tick();
        bus.POWER_GOOD = 1'b0;
        tick();
        chk("pg_drop_all", 32'(outs), 32'(RST_VEC));
        chk("pg_drop_inp", 32'(bus.INP_DIS), 32'h3);
        chk("pg_drop_rdy", 32'(bus.CFG_READY), 32'h0);
        tick();
        chk("pg_off_hold", 32'(outs), 32'(RST_VEC));

        // Asynchronous reset during SETTLE, then a full repeat of bring-up.
        bus.POWER_GOOD = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("settle_ref", 32'(bus.HLD_H_N_REFGEN), 32'h1);
        #2;
        RESET_B = 1'b0;
        #1;
        chk("rst_async_all", 32'(outs), 32'(RST_VEC));
        @(negedge CLK);
        RESET_B = 1'b1;
        bringup("up2");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
